// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner.
// Holds FSM states, scan classes and a row-hit counter.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  typedef enum logic [1:0] {
    SC_NONE,
    SC_SINGLE,
    SC_MULTI
  } scan_t;

  function automatic logic [2:0] hit_count(
    input logic [NUM_ROWS-1:0] rn
  );
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_ROWS; i++)
      n = n + {2'b00, ~rn[i]};
    return n;
  endfunction

endpackage

// File: rtl/keypad_scanner_sync2.sv
// Two-flop synchronizer for asynchronous inputs.
// Resets to all-ones (idle level of active-low rows).
module sync2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  // two back-to-back flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '1;
      q  <= '1;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner with per-scan debounce.
// Drives one column low at a time, accepts single keys.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_ROWS-1:0] row,
  output logic [NUM_COLS-1:0] col,
  output logic [3:0]          buttonNum,
  output logic                valid,
  output logic                pressed
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] rs;
  logic [DW-1:0] dwell;
  logic [1:0] cidx;
  logic last;
  logic scan_end;

  logic [2:0] col_n;
  logic [1:0] col_r;
  logic [1:0] acc_n;
  logic [3:0] acc_k;
  logic [1:0] sum_n;
  logic [3:0] sum_k;
  scan_t cls;

  state_t state, state_n;
  logic [3:0] dcnt, dcnt_n;
  logic [3:0] cand, cand_n;
  logic [3:0] bnum_n;
  logic pressed_n;

  sync2 #(.W(NUM_ROWS)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (row),
    .q       (rs)
  );

  assign last     = (dwell == LAST);
  assign scan_end = last && (cidx == 2'd3);
  assign col      = ~(4'b0001 << cidx);
  assign valid    = (state == ST_HELD) ||
                    (state == ST_RELEASE);

  // free-running dwell counter and column index
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dwell <= '0;
      cidx  <= '0;
    end else if (last) begin
      dwell <= '0;
      cidx  <= cidx + 2'd1;
    end else begin
      dwell <= dwell + DW'(1);
    end
  end

  // hits in the current column and lowest hit row
  always_comb begin
    col_n = hit_count(rs);
    col_r = '0;
    for (int i = NUM_ROWS - 1; i >= 0; i--)
      if (!rs[i]) col_r = 2'(i);
  end

  // merge this column into the running scan result
  always_comb begin
    sum_n = (cidx == 2'd0) ? 2'd0 : acc_n;
    sum_k = acc_k;
    if (col_n == 3'd1 && sum_n == 2'd0) begin
      sum_n = 2'd1;
      sum_k = {cidx, col_r};
    end else if (col_n != 3'd0) begin
      sum_n = 2'd2;
    end
    unique case (sum_n)
      2'd0:    cls = SC_NONE;
      2'd1:    cls = SC_SINGLE;
      default: cls = SC_MULTI;
    endcase
  end

  // per-scan accumulator, updated on each column sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_n <= '0;
      acc_k <= '0;
    end else if (last) begin
      acc_n <= sum_n;
      acc_k <= sum_k;
    end
  end

  // debounce FSM state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      dcnt      <= '0;
      cand      <= '0;
      buttonNum <= '0;
      pressed   <= 1'b0;
    end else begin
      state     <= state_n;
      dcnt      <= dcnt_n;
      cand      <= cand_n;
      buttonNum <= bnum_n;
      pressed   <= pressed_n;
    end
  end

  // next state, evaluated only at scan end
  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    cand_n    = cand;
    bnum_n    = buttonNum;
    pressed_n = 1'b0;
    if (scan_end) begin
      unique case (state)
        ST_IDLE: begin
          if (cls == SC_SINGLE) begin
            cand_n = sum_k;
            if (DS == 4'd1) begin
              state_n   = ST_HELD;
              bnum_n    = sum_k;
              pressed_n = 1'b1;
              dcnt_n    = '0;
            end else begin
              state_n = ST_DEBOUNCE;
              dcnt_n  = 4'd1;
            end
          end
        end
        ST_DEBOUNCE: begin
          if (cls == SC_SINGLE && sum_k == cand) begin
            if (dcnt + 4'd1 >= DS) begin
              state_n   = ST_HELD;
              bnum_n    = cand;
              pressed_n = 1'b1;
              dcnt_n    = '0;
            end else begin
              dcnt_n = dcnt + 4'd1;
            end
          end else if (cls == SC_SINGLE) begin
            cand_n = sum_k;
            dcnt_n = 4'd1;
          end else begin
            state_n = ST_IDLE;
            dcnt_n  = '0;
          end
        end
        ST_HELD: begin
          if (cls == SC_NONE) begin
            if (DS == 4'd1) begin
              state_n = ST_IDLE;
              dcnt_n  = '0;
            end else begin
              state_n = ST_RELEASE;
              dcnt_n  = 4'd1;
            end
          end
        end
        ST_RELEASE: begin
          if (cls == SC_NONE) begin
            if (dcnt + 4'd1 >= DS) begin
              state_n = ST_IDLE;
              dcnt_n  = '0;
            end else begin
              dcnt_n = dcnt + 4'd1;
            end
          end else begin
            state_n = ST_HELD;
            dcnt_n  = '0;
          end
        end
      endcase
    end
  end

endmodule
